// File: rtl/dmem_io_unit_pkg.sv
// Shared definitions for the data-side memory/IO block:
// I/O offsets, status word layout and region decode.
package dmem_io_pkg;

    localparam logic [15:0] IO_TX_OFS   = 16'd0;
    localparam logic [15:0] IO_STAT_OFS = 16'd1;

    localparam int OVF_BIT   = 15;
    localparam int COUNT_LSB = 0;
    localparam int COUNT_W   = 4;

    typedef enum logic [1:0] {
        REG_RAM,
        REG_TX,
        REG_STAT,
        REG_NONE
    } region_e;

    function automatic logic [15:0] stat_word(
        input logic               ovf,
        input logic [COUNT_W-1:0] cnt
    );
        logic [15:0] w;
        w                        = '0;
        w[OVF_BIT]               = ovf;
        w[COUNT_LSB +: COUNT_W]  = cnt;
        return w;
    endfunction

endpackage

// File: rtl/dmem_io_unit_if.sv
// Ready/valid output stream carrying TX FIFO words
// to the external consumer.
interface dmem_io_unit_if #(
    parameter int W = 16
);
    logic [W-1:0] OUT_DATA;
    logic         OUT_VALID;
    logic         OUT_READY;

    modport master (
        output OUT_DATA,
        output OUT_VALID,
        input  OUT_READY
    );

    modport slave (
        input  OUT_DATA,
        input  OUT_VALID,
        output OUT_READY
    );
endinterface

// File: rtl/dmem_io_unit_tx_fifo.sv
// Circular-buffer TX FIFO; state advances on the falling clock edge.
// A pop in the same edge frees a slot, so a push into a full FIFO lands.
module tx_fifo #(
    parameter int WIDTH = 16,
    parameter int DEPTH = 4,
    localparam int PW   = $clog2(DEPTH),
    localparam int CW   = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] head,
    output logic [CW-1:0]    count,
    output logic             full,
    output logic             empty
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]    count_q, count_d;
    logic             push_ok, pop_ok;

    assign empty = (count_q == '0);
    assign full  = (count_q == CW'(DEPTH));
    assign count = count_q;
    assign head  = empty ? '0 : mem[rd_ptr_q];

    always_comb begin
        pop_ok   = pop & ~empty;
        push_ok  = push & (~full | pop_ok);
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push_ok) wr_ptr_d = wr_ptr_q + PW'(1);
        if (pop_ok)  rd_ptr_d = rd_ptr_q + PW'(1);
        case ({push_ok, pop_ok})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(negedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage is not reset; count gates visibility of stale entries.
    always_ff @(negedge clk) begin
        if (push_ok) mem[wr_ptr_q] <= push_data;
    end

endmodule

// File: rtl/dmem_io_unit.sv
// Data RAM plus memory-mapped TX port on the CPU DA/DD/RW bus.
// Acts on the negedge between CPU posedges; DD driven only on reads.
module dmem_io_unit
    import dmem_io_pkg::*;
#(
    parameter int          AW         = 7,
    parameter logic [15:0] IO_BASE    = 16'hFF00,
    parameter int          FIFO_DEPTH = 4
) (
    input  logic                  CK,
    input  logic                  RST,
    input  logic [15:0]           DA,
    inout  wire  [15:0]           DD,
    input  logic                  RW,
    dmem_io_unit_if.master        tx
);

    localparam int CW = $clog2(FIFO_DEPTH + 1);

    logic [15:0] ram [2**AW];
    logic [15:0] rd_q, rd_d;
    logic        ovf_q, ovf_d;
    region_e     region;
    logic        ram_we;
    logic        push, pop, drop;
    logic [15:0] head;
    logic [CW-1:0] count;
    logic        full, empty;

    always_comb begin
        region = REG_NONE;
        if (DA[15:AW] == '0)
            region = REG_RAM;
        else if (DA == IO_BASE + IO_TX_OFS)
            region = REG_TX;
        else if (DA == IO_BASE + IO_STAT_OFS)
            region = REG_STAT;
    end

    assign pop  = tx.OUT_VALID & tx.OUT_READY;
    assign drop = push & full & ~pop;

    // Writes only on a definite RW=0; an unknown RW falls to the read path.
    always_comb begin
        ram_we = 1'b0;
        push   = 1'b0;
        rd_d   = rd_q;
        ovf_d  = ovf_q;
        if (RW == 1'b0) begin
            unique case (region)
                REG_RAM:  ram_we = 1'b1;
                REG_TX:   push   = 1'b1;
                REG_STAT: ovf_d  = 1'b0;
                default:  ;
            endcase
        end else begin
            unique case (region)
                REG_RAM:  rd_d = ram[DA[AW-1:0]];
                REG_TX:   rd_d = head;
                REG_STAT: rd_d = stat_word(ovf_q, COUNT_W'(count));
                default:  rd_d = '0;
            endcase
        end
        if (drop) ovf_d = 1'b1;
    end

    always_ff @(negedge CK or posedge RST) begin
        if (RST) begin
            rd_q  <= '0;
            ovf_q <= 1'b0;
        end else begin
            rd_q  <= rd_d;
            ovf_q <= ovf_d;
        end
    end

    always_ff @(negedge CK) begin
        if (ram_we) ram[DA[AW-1:0]] <= DD;
    end

    tx_fifo #(
        .WIDTH (16),
        .DEPTH (FIFO_DEPTH)
    ) u_tx_fifo (
        .clk       (CK),
        .rst       (RST),
        .push      (push),
        .push_data (DD),
        .pop       (pop),
        .head      (head),
        .count     (count),
        .full      (full),
        .empty     (empty)
    );

    assign tx.OUT_DATA  = head;
    assign tx.OUT_VALID = ~empty;

    assign DD = RW ? rd_q : 'z;

endmodule
